// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, imem write port and core-reset status out.
interface imem_loader_if #(parameter int ADDR_WIDTH = 8);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  core_reset;
  logic                  load_done;
  logic                  load_error;

  // master = host byte source / bench, slave = loader
  modport master (output rx_valid, rx_data,
                  input  rx_ready, imem_we, imem_addr, imem_wdata,
                         core_reset, load_done, load_error);
  modport slave  (input  rx_valid, rx_data,
                  output rx_ready, imem_we, imem_addr, imem_wdata,
                         core_reset, load_done, load_error);
endinterface

// File: rtl/imem_loader_word_packer.sv
// Assembles four little-endian bytes into a word; word_valid marks the 4th byte.
module word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [1:0]  lane;
  logic [23:0] sr;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane <= '0;
      sr   <= '0;
    end else if (byte_valid) begin
      lane <= lane + 2'd1;
      sr   <= {byte_in, sr[23:8]};
    end
  end

  // lane-3 byte completes the word combinationally; the top registers it
  assign word_valid = byte_valid && (lane == 2'd3);
  assign word       = {byte_in, sr};
endmodule

// File: rtl/imem_loader.sv
// Frame parser: sync, 16-bit word count, LE words, XOR checksum; holds core in reset until a verified load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus
);
  localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;

  state_t      state, nstate;
  logic [15:0] cnt;
  logic [16:0] idx;
  logic [7:0]  csum;
  logic        rdy, acc, sync, pk_valid, last_word;
  logic [31:0] pk_word;
  logic [16:0] len;

  assign rdy       = (state != DONE);
  assign acc       = bus.rx_valid && rdy;
  assign sync      = (bus.rx_data == SYNC_BYTE);
  assign len       = {1'b0, bus.rx_data, cnt[7:0]};
  assign last_word = pk_valid && ((idx + 17'd1) == {1'b0, cnt});

  word_packer u_pack (
    .clk        (clk),
    .reset      (reset),
    .clear      (acc && state == LEN1),
    .byte_valid (acc && state == DATA),
    .byte_in    (bus.rx_data),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    if (acc) begin
      case (state)
        IDLE, ERR: if (sync) nstate = LEN0;
        LEN0:      nstate = LEN1;
        LEN1: begin
          if (len == '0)      nstate = CSUM;
          else if (len > CAP) nstate = ERR;
          else                nstate = DATA;
        end
        DATA:      if (last_word) nstate = CSUM;
        CSUM:      nstate = (bus.rx_data == csum) ? DONE : ERR;
        default:   nstate = state;
      endcase
    end
  end

  assign bus.rx_ready   = rdy;
  assign bus.core_reset = (state != DONE);
  assign bus.load_done  = (state == DONE);
  assign bus.load_error = (state == ERR);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt            <= '0;
      idx            <= '0;
      csum           <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
    end else begin
      bus.imem_we <= acc && (state == DATA) && pk_valid;
      if (acc) begin
        case (state)
          IDLE, ERR: if (sync) csum <= '0;
          LEN0: begin
            cnt[7:0] <= bus.rx_data;
            csum     <= csum ^ bus.rx_data;
          end
          LEN1: begin
            cnt[15:8] <= bus.rx_data;
            csum      <= csum ^ bus.rx_data;
            idx       <= '0;
          end
          DATA: begin
            csum <= csum ^ bus.rx_data;
            if (pk_valid) begin
              bus.imem_addr  <= idx[ADDR_WIDTH-1:0];
              bus.imem_wdata <= pk_word;
              idx            <= idx + 17'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader (small 4-word memory to reach the oversize boundary).
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int AW  = 2;
  localparam int CAP = 1 << AW;

  typedef logic [7:0]  byteq_t[$];
  typedef logic [31:0] wordq_t[$];
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus();
  imem_loader #(.ADDR_WIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  wr_t expq[$];
  int  checks  = 0;
  int  errors  = 0;
  int  nwrites = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // write monitor: every strobe must match the oldest outstanding expected write
  always @(negedge clk) begin
    wr_t e;
    if (bus.imem_we === 1'b1) begin
      nwrites++;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %h expected no write", bus.imem_addr, bus.imem_wdata);
      end else begin
        e = expq.pop_front();
        chk("wr_addr", 32'(bus.imem_addr), 32'(e.addr));
        chk("wr_data", bus.imem_wdata, e.data);
      end
    end
  end

  task automatic chk_status(input string name, input bit done, input bit err);
    chk({name, "_done"},       32'(bus.load_done),  32'(done));
    chk({name, "_error"},      32'(bus.load_error), 32'(err));
    chk({name, "_core_reset"}, 32'(bus.core_reset), 32'(!done));
    chk({name, "_rx_ready"},   32'(bus.rx_ready),   32'(!done));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout: got rx_ready %b expected 1 within 50 cycles", bus.rx_ready);
      bus.rx_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input byteq_t q, input int maxgap);
    foreach (q[i]) send_byte(q[i], int'($urandom_range(maxgap, 0)));
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_rx_ready",   32'(bus.rx_ready),   1);
    chk("rst_imem_we",    32'(bus.imem_we),    0);
    chk("rst_imem_addr",  32'(bus.imem_addr),  0);
    chk("rst_imem_wdata", bus.imem_wdata,      0);
    chk("rst_core_reset", 32'(bus.core_reset), 1);
    chk("rst_load_done",  32'(bus.load_done),  0);
    chk("rst_load_error", 32'(bus.load_error), 0);
    reset = 1'b0;
  endtask

  task automatic settle(input string name, input int n0, input int exp_n);
    @(negedge clk);
    #1;
    chk({name, "_writes"}, 32'(nwrites - n0), 32'(exp_n));
    chk({name, "_expq_empty"}, 32'(expq.size()), 0);
  endtask

  // spec example frame A5 01 00 78 56 34 12 <last>
  task automatic basic_raw(input string name, input logic [7:0] last, input int maxgap, input bit ok);
    byteq_t q;
    int n0 = nwrites;
    q = {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, last};
    expq.push_back('{addr: '0, data: 32'h1234_5678});
    send_bytes(q, maxgap);
    chk_status(name, ok, !ok);
    settle(name, n0, 1);
  endtask

  // reference model: frame-level rules (XOR over count+data bytes, cap check, words at 0..n-1)
  task automatic run_frame(input string name, input wordq_t w, input int cnt,
                           input logic [7:0] flip, input int maxgap);
    byteq_t q;
    logic [7:0] x, b;
    int n0 = nwrites;
    q = {SYNC_BYTE, 8'(cnt), 8'(cnt >> 8)};
    x = 8'(cnt) ^ 8'(cnt >> 8);
    if (cnt > CAP) begin
      send_bytes(q, maxgap);
      chk_status({name, "_oversize"}, 1'b0, 1'b1);
      q = {};
      for (int i = 0; i < 4; i++) begin
        b = 8'($urandom);
        if (b == SYNC_BYTE) b = 8'h00;
        q.push_back(b);
      end
      send_bytes(q, maxgap);
      chk_status({name, "_discard"}, 1'b0, 1'b1);
      settle(name, n0, 0);
    end else begin
      foreach (w[i]) begin
        expq.push_back('{addr: AW'(i), data: w[i]});
        for (int k = 0; k < 4; k++) begin
          b = w[i][8*k +: 8];
          q.push_back(b);
          x ^= b;
        end
      end
      q.push_back(x ^ flip);
      send_bytes(q, maxgap);
      chk_status(name, flip == 8'h00, flip != 8'h00);
      settle(name, n0, cnt);
    end
  endtask

  function automatic wordq_t rand_words(input int n);
    wordq_t w;
    for (int i = 0; i < n; i++) w.push_back($urandom);
    return w;
  endfunction

  initial begin
    byteq_t q;
    wordq_t w;
    int n0, cnt;
    logic [7:0] flip;

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    do_reset();

    basic_raw("basic", 8'h09, 0, 1'b1);

    do_reset();
    q = {8'h00, 8'hFF, 8'h3C};
    send_bytes(q, 5);
    chk_status("hunt_idle", 1'b0, 1'b0);
    basic_raw("hunt", 8'h09, 5, 1'b1);

    do_reset();
    basic_raw("badsum", 8'h08, 0, 1'b0);
    n0 = nwrites;
    send_byte(8'hA5, 0);
    chk("retry_err_clear", 32'(bus.load_error), 0);
    chk("retry_core_reset", 32'(bus.core_reset), 1);
    expq.push_back('{addr: '0, data: 32'h1234_5678});
    q = {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
    send_bytes(q, 2);
    chk_status("retry", 1'b1, 1'b0);
    settle("retry", n0, 1);

    do_reset();
    w = {};
    run_frame("empty", w, 0, 8'h00, 0);

    do_reset();
    run_frame("over5", w, 5, 8'h00, 1);

    do_reset();
    run_frame("full4", rand_words(CAP), CAP, 8'h00, 1);

    do_reset();
    n0 = nwrites;
    q = {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
    send_bytes(q, 0);
    do_reset();
    settle("midword", n0, 0);
    run_frame("after_rst", rand_words(2), 2, 8'h00, 1);

    for (int it = 0; it < 25; it++) begin
      do_reset();
      if ($urandom_range(9, 0) == 0) cnt = int'($urandom_range(65535, CAP + 1));
      else                           cnt = int'($urandom_range(CAP, 0));
      flip = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      run_frame("rand", rand_words(cnt > CAP ? 0 : cnt), cnt, flip, 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end
endmodule
